// File: rtl/lcd_nibble_writer_if.sv
// lcd_nibble_writer_if
// Request/response and LCD pin bundle for the nibble writer.
//   iStart, iData[7:0], iRS : write request from the CPU execute stage
//   oReady, oDone           : accept/complete handshake back to the CPU
//   oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data[3:0] : Spartan-3E character LCD pins
// The master modport is the CPU side. The slave modport is the writer.
interface lcd_nibble_writer_if;
  logic       iStart;
  logic [7:0] iData;
  logic       iRS;
  logic       oReady;
  logic       oDone;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  modport master (
    output iStart, iData, iRS,
    input  oReady, oDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );

  modport slave (
    input  iStart, iData, iRS,
    output oReady, oDone, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );
endinterface

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer
// Sends the upper nibble of one register value to the character LCD (4-bit
// mode). The module generates setup, enable pulse, hold and recovery timing in
// hardware.
//   Clock : 50 MHz system clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : lcd_nibble_writer_if.slave. Carries the start/data/RS request, the
//           ready/done handshake and the registered LCD pins.
// Each timing state lasts exactly N cycles. A 16-bit down-counter is loaded
// with N-1 on entry, and the state is left when the counter reaches 0.
module lcd_nibble_writer #(
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned PULSE_CYCLES    = 12,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned RECOVERY_CYCLES = 50
) (
  input logic                Clock,
  input logic                Reset,
  lcd_nibble_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOVER} state_t;

  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REC_LD   = 16'(RECOVERY_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [3:0]  data_q, data_d;
  logic        finish;
  logic        cnt_zero;

  // The low nibble of the register value is never sent.
  logic unused_low_nibble;
  assign unused_low_nibble = ^bus.iData[3:0];

  assign cnt_zero = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;
    finish  = 1'b0;

    case (state_q)
      IDLE: ;
      SETUP: begin
        if (cnt_zero) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          if (RECOVERY_CYCLES == 0) begin
            finish = 1'b1;
          end else begin
            state_d = RECOVER;
            cnt_d   = REC_LD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RECOVER: begin
        if (cnt_zero) finish = 1'b1;
        else          cnt_d  = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
      ready_d = 1'b1;
      done_d  = 1'b1;
    end

    // A start is taken in IDLE and also on the completing edge itself.
    // This allows back-to-back writes without a gap cycle. oDone still
    // pulses for the write that just finished.
    if ((state_q == IDLE || finish) && bus.iStart) begin
      state_d = SETUP;
      cnt_d   = SETUP_LD;
      ready_d = 1'b0;
      rs_d    = bus.iRS;
      data_d  = bus.iData[7:4];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign bus.oReady    = ready_q;
  assign bus.oDone     = done_q;
  assign bus.oLCD_E    = e_q;
  assign bus.oLCD_RS   = rs_q;
  assign bus.oLCD_Data = data_q;
  // Write-only interface, so RW is tied low.
  assign bus.oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer. Instance "a" uses the default timing.
// Instance "b" uses the minimal timing: setup, pulse and hold of 1 cycle each,
// with no recovery. Cycle index k counts edges after the accepting edge T
// (k=0 is edge T). Outputs are sampled 1 time unit after each rising edge.
module tb_lcd_nibble_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lcd_nibble_writer_if if_a();
  lcd_nibble_writer_if if_b();

  lcd_nibble_writer u_a (.Clock(clk), .Reset(rst), .bus(if_a.slave));

  lcd_nibble_writer #(
    .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .RECOVERY_CYCLES(0)
  ) u_b (.Clock(clk), .Reset(rst), .bus(if_b.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (if_a.oReady !== 1'b1 || if_a.oDone !== 1'b0 || if_a.oLCD_E !== 1'b0 ||
        if_a.oLCD_RS !== 1'b0 || if_a.oLCD_RW !== 1'b0 || if_a.oLCD_Data !== 4'h0) begin
      errors++;
      $display("FAIL reset_a got rdy=%b done=%b e=%b rs=%b rw=%b d=%h exp 1 0 0 0 0 0",
               if_a.oReady, if_a.oDone, if_a.oLCD_E, if_a.oLCD_RS, if_a.oLCD_RW, if_a.oLCD_Data);
    end
    checks++;
    if (if_b.oReady !== 1'b1 || if_b.oLCD_E !== 1'b0 || if_b.oDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got rdy=%b e=%b done=%b exp 1 0 0", if_b.oReady, if_b.oLCD_E, if_b.oDone);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_single_write();
    logic e_x, r_x, d_x;
    if_a.iData = 8'h28; if_a.iRS = 1'b0; if_a.iStart = 1'b1;
    for (int k = 0; k <= 66; k++) begin
      tick();
      if (k == 0) if_a.iStart = 1'b0;
      e_x = (k >= 2 && k < 14);
      r_x = (k >= 65);
      d_x = (k == 65);
      checks++;
      if (if_a.oLCD_E !== e_x) begin errors++; $display("FAIL single_e k=%0d got %b exp %b", k, if_a.oLCD_E, e_x); end
      checks++;
      if (if_a.oReady !== r_x) begin errors++; $display("FAIL single_ready k=%0d got %b exp %b", k, if_a.oReady, r_x); end
      checks++;
      if (if_a.oDone !== d_x) begin errors++; $display("FAIL single_done k=%0d got %b exp %b", k, if_a.oDone, d_x); end
      checks++;
      if (if_a.oLCD_Data !== 4'h2 || if_a.oLCD_RS !== 1'b0) begin
        errors++; $display("FAIL single_data k=%0d got %h/%b exp 2/0", k, if_a.oLCD_Data, if_a.oLCD_RS);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e_x, r_x, d_x;
    logic [3:0] dat_x;
    if_a.iData = 8'h28; if_a.iRS = 1'b1; if_a.iStart = 1'b1;
    for (int k = 0; k <= 131; k++) begin
      tick();
      if (k == 0 || k == 65) if_a.iStart = 1'b0;
      e_x   = (k >= 2 && k < 14) || (k >= 67 && k < 79);
      r_x   = (k >= 130);
      d_x   = (k == 65) || (k == 130);
      dat_x = (k < 65) ? 4'h2 : 4'h8;
      checks++;
      if (if_a.oLCD_E !== e_x) begin errors++; $display("FAIL b2b_e k=%0d got %b exp %b", k, if_a.oLCD_E, e_x); end
      checks++;
      if (if_a.oReady !== r_x || if_a.oDone !== d_x) begin
        errors++; $display("FAIL b2b_hs k=%0d got rdy=%b done=%b exp %b %b", k, if_a.oReady, if_a.oDone, r_x, d_x);
      end
      checks++;
      if (if_a.oLCD_Data !== dat_x || if_a.oLCD_RS !== 1'b1) begin
        errors++; $display("FAIL b2b_data k=%0d got %h/%b exp %h/1", k, if_a.oLCD_Data, if_a.oLCD_RS, dat_x);
      end
      // Request the second nibble so that it is sampled on the completing edge.
      if (k == 64) begin if_a.iStart = 1'b1; if_a.iData = 8'h80; end
    end
  endtask

  task automatic test_ignored_start();
    int e_cnt = 0;
    int d_cnt = 0;
    if_a.iData = 8'h28; if_a.iRS = 1'b0; if_a.iStart = 1'b1;
    for (int k = 0; k <= 66; k++) begin
      tick();
      if (k == 0 || k == 5 || k == 30) if_a.iStart = 1'b0;
      if (if_a.oLCD_E === 1'b1) e_cnt++;
      if (if_a.oDone === 1'b1) d_cnt++;
      checks++;
      if (if_a.oLCD_Data !== 4'h2 || if_a.oLCD_RS !== 1'b0) begin
        errors++; $display("FAIL busy_data k=%0d got %h/%b exp 2/0", k, if_a.oLCD_Data, if_a.oLCD_RS);
      end
      checks++;
      if (if_a.oReady !== (k >= 65)) begin
        errors++; $display("FAIL busy_ready k=%0d got %b exp %b", k, if_a.oReady, (k >= 65));
      end
      if (k == 4 || k == 29) begin if_a.iStart = 1'b1; if_a.iData = 8'hFF; if_a.iRS = 1'b1; end
    end
    checks++;
    if (e_cnt != 12) begin errors++; $display("FAIL busy_e_cycles got %0d exp 12", e_cnt); end
    checks++;
    if (d_cnt != 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", d_cnt); end
  endtask

  task automatic test_reset_mid_pulse();
    int bad = 0;
    if_a.iData = 8'h28; if_a.iRS = 1'b1; if_a.iStart = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) if_a.iStart = 1'b0;
    end
    checks++;
    if (if_a.oLCD_E !== 1'b1) begin errors++; $display("FAIL rstmid_pre_e got %b exp 1", if_a.oLCD_E); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (if_a.oLCD_E !== 1'b0 || if_a.oReady !== 1'b1 || if_a.oLCD_Data !== 4'h0 || if_a.oLCD_RS !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got e=%b rdy=%b d=%h rs=%b exp 0 1 0 0",
               if_a.oLCD_E, if_a.oReady, if_a.oLCD_Data, if_a.oLCD_RS);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 70; k++) begin
      tick();
      if (if_a.oDone !== 1'b0 || if_a.oLCD_E !== 1'b0 || if_a.oReady !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d bad cycles exp 0", bad); end
    if_a.iData = 8'h80; if_a.iRS = 1'b0; if_a.iStart = 1'b1;
    for (int k = 0; k <= 66; k++) begin
      tick();
      if (k == 0) if_a.iStart = 1'b0;
      if (k == 1 || k == 2 || k == 13 || k == 14 || k == 64 || k == 65 || k == 66) begin
        checks++;
        if (if_a.oLCD_E !== (k == 2 || k == 13) || if_a.oDone !== (k == 65) || if_a.oLCD_Data !== 4'h8) begin
          errors++;
          $display("FAIL rstmid_fresh k=%0d got e=%b done=%b d=%h exp %b %b 8",
                   k, if_a.oLCD_E, if_a.oDone, if_a.oLCD_Data, (k == 2 || k == 13), (k == 65));
        end
      end
    end
  endtask

  task automatic test_fast();
    logic e_x, r_x, d_x;
    if_b.iData = 8'h3C; if_b.iRS = 1'b1; if_b.iStart = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) if_b.iStart = 1'b0;
      checks++;
      if (if_b.oLCD_E !== (k == 1) || if_b.oDone !== (k == 3) || if_b.oReady !== (k >= 3)) begin
        errors++;
        $display("FAIL fast_single k=%0d got e=%b done=%b rdy=%b exp %b %b %b",
                 k, if_b.oLCD_E, if_b.oDone, if_b.oReady, (k == 1), (k == 3), (k >= 3));
      end
    end
    if_b.iStart = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 6) if_b.iStart = 1'b0;
      e_x = (k == 1 || k == 4 || k == 7);
      d_x = (k == 3 || k == 6 || k == 9);
      r_x = (k >= 9);
      checks++;
      if (if_b.oLCD_E !== e_x || if_b.oDone !== d_x || if_b.oReady !== r_x || if_b.oLCD_Data !== 4'h3) begin
        errors++;
        $display("FAIL fast_b2b k=%0d got e=%b done=%b rdy=%b d=%h exp %b %b %b 3",
                 k, if_b.oLCD_E, if_b.oDone, if_b.oReady, if_b.oLCD_Data, e_x, d_x, r_x);
      end
    end
  endtask

  task automatic test_data_stable();
    if_a.iData = 8'h5A; if_a.iRS = 1'b1; if_a.iStart = 1'b1;
    for (int k = 0; k <= 65; k++) begin
      tick();
      if_a.iStart = 1'b0;
      if_a.iData  = 8'($urandom);
      if_a.iRS    = ~if_a.iRS;
      checks++;
      if (if_a.oLCD_Data !== 4'h5 || if_a.oLCD_RS !== 1'b1 || if_a.oLCD_RW !== 1'b0) begin
        errors++;
        $display("FAIL stable k=%0d got d=%h rs=%b rw=%b exp 5 1 0", k, if_a.oLCD_Data, if_a.oLCD_RS, if_a.oLCD_RW);
      end
    end
    checks++;
    if (if_a.oDone !== 1'b1) begin errors++; $display("FAIL stable_done got %b exp 1", if_a.oDone); end
  endtask

  initial begin
    if_a.iStart = 1'b0; if_a.iData = 8'h00; if_a.iRS = 1'b0;
    if_b.iStart = 1'b0; if_b.iData = 8'h00; if_b.iRS = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_pulse();
    test_fast();
    test_data_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
